// File: rtl/eth_mac_rx_noc_out.sv
// eth_mac_rx_noc_out: buffers whole MAC RX frames and forwards each one as a NoC message (header + body flits)
// Optional feature macro: ETH_MAC_RX_DROP_CNT_EN enables the dropped-frame counter (drop_cnt reads 0 otherwise).
// Header flit, MSB first: dst_x[8] dst_y[8] src_x[8] src_y[8] msg_len[8] msg_type[8] frame_size[16], rest zero.
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 512
`endif
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 6
`endif
`ifndef MTU_SIZE_W
`define MTU_SIZE_W 16
`endif

module eth_mac_rx_noc_out #(
    parameter int SRC_X = -1,
    parameter int SRC_Y = -1,
    parameter int DST_X = -1,
    parameter int DST_Y = -1,
    parameter int BUF_FLITS = 512,
    parameter int MAX_FRAME_FLITS = 150,
    parameter int SIZE_FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mac_eth_rx_val,
    input  logic [`MAC_INTERFACE_W-1:0]   mac_eth_rx_data,
    input  logic                          mac_eth_rx_last,
    input  logic [`MAC_PADBYTES_W-1:0]    mac_eth_rx_padbytes,
    input  logic                          mac_eth_rx_err,
    output logic                          eth_rx_out_noc_val,
    output logic [`NOC_DATA_WIDTH-1:0]    eth_rx_out_noc_data,
    input  logic                          noc_eth_rx_out_rdy,
    output logic [31:0]                   drop_cnt
);
    localparam int DW = `NOC_DATA_WIDTH;
    localparam int B = `MAC_INTERFACE_W / 8;
    localparam int PW = $clog2(BUF_FLITS) + 1;
    localparam int AW = PW - 1;
    localparam int BW = $clog2(MAX_FRAME_FLITS + 2);
    localparam int SW = `MTU_SIZE_W;
    localparam int DPW = $clog2(SIZE_FIFO_DEPTH) + 1;
    localparam logic [7:0] ETH_RX_FRAME = 8'd18;
    localparam logic [7:0] SX = 8'(SRC_X);
    localparam logic [7:0] SY = 8'(SRC_Y);
    localparam logic [7:0] DX = 8'(DST_X);
    localparam logic [7:0] DY = 8'(DST_Y);

    typedef enum logic [1:0] {WR_IDLE, WR_ACCEPT, WR_DROP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_HDR, RD_BODY} rd_state_t;

    wr_state_t wr_state, wr_state_n;
    rd_state_t rd_state, rd_state_n;
    logic [PW-1:0] wr_spec, wr_spec_n, wr_commit, wr_commit_n, rd_ptr, rd_iss, rd_iss_n, buf_used;
    logic [BW-1:0] wr_beats, wr_beats_n, beat_n, rd_left, rd_left_n, cur_beats;
    logic [SW-1:0] wr_size, wr_size_n, size_n, cur_size;
    logic [DPW-1:0] desc_wp, desc_rp, desc_fp, desc_fp_n;
    logic [SW+BW-1:0] desc_mem [SIZE_FIFO_DEPTH];
    logic [DW-1:0] buf_mem [BUF_FLITS];
    logic [DW-1:0] rdata, hdr;
    logic [DW+1:0] q0, q1, push_ent;
    logic [1:0] occ, room_used;
    logic first, take, start_ok, desc_full, desc_avail, wr_en, desc_push, drop;
    logic issue, issue_last, hdr_push, rv, rv_last, pop, push;

    assign buf_used = wr_spec - rd_ptr;
    assign desc_full = (desc_wp - desc_rp) == DPW'(SIZE_FIFO_DEPTH);
    assign desc_avail = desc_wp != desc_fp;
    assign start_ok = (32'(buf_used) + 32'(MAX_FRAME_FLITS) <= 32'(BUF_FLITS)) && !desc_full;
    assign first = wr_state == WR_IDLE;
    assign take = mac_eth_rx_val && (wr_state == WR_ACCEPT || (first && start_ok));
    assign beat_n = first ? BW'(1) : wr_beats + BW'(1);
    assign size_n = (first ? SW'(0) : wr_size)
                  + (mac_eth_rx_last ? SW'(B) - SW'(mac_eth_rx_padbytes) : SW'(B));

    // Write FSM: admit, store, commit or rewind each incoming frame
    always_comb begin
        wr_state_n = wr_state;
        wr_spec_n = wr_spec;
        wr_commit_n = wr_commit;
        wr_beats_n = wr_beats;
        wr_size_n = wr_size;
        wr_en = 1'b0;
        desc_push = 1'b0;
        drop = 1'b0;
        if (mac_eth_rx_val && first && !start_ok) begin
            drop = 1'b1;
            wr_state_n = mac_eth_rx_last ? WR_IDLE : WR_DROP;
        end else if (mac_eth_rx_val && wr_state == WR_DROP) begin
            wr_state_n = mac_eth_rx_last ? WR_IDLE : WR_DROP;
        end else if (take) begin
            if (32'(beat_n) > 32'(MAX_FRAME_FLITS)) begin
                drop = 1'b1;
                wr_spec_n = wr_commit;
                wr_state_n = mac_eth_rx_last ? WR_IDLE : WR_DROP;
            end else if (mac_eth_rx_last && mac_eth_rx_err) begin
                drop = 1'b1;
                wr_spec_n = wr_commit;
                wr_state_n = WR_IDLE;
            end else begin
                wr_en = 1'b1;
                wr_spec_n = wr_spec + PW'(1);
                wr_beats_n = beat_n;
                wr_size_n = size_n;
                desc_push = mac_eth_rx_last;
                wr_commit_n = mac_eth_rx_last ? wr_spec + PW'(1) : wr_commit;
                wr_state_n = mac_eth_rx_last ? WR_IDLE : WR_ACCEPT;
            end
        end
    end

    // Write-side state, speculative and committed pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= WR_IDLE;
            wr_spec <= '0;
            wr_commit <= '0;
            wr_beats <= '0;
            wr_size <= '0;
        end else begin
            wr_state <= wr_state_n;
            wr_spec <= wr_spec_n;
            wr_commit <= wr_commit_n;
            wr_beats <= wr_beats_n;
            wr_size <= wr_size_n;
        end
    end

    // Frame buffer write port
    always_ff @(posedge clk) begin
        if (wr_en) buf_mem[wr_spec[AW-1:0]] <= mac_eth_rx_data;
    end

    // Descriptor FIFO: one {size, beats} entry per committed frame
    always_ff @(posedge clk) begin
        if (desc_push) desc_mem[desc_wp[DPW-2:0]] <= {size_n, beat_n};
        if (rst) desc_wp <= '0;
        else if (desc_push) desc_wp <= desc_wp + DPW'(1);
    end

    assign {cur_size, cur_beats} = desc_mem[desc_fp[DPW-2:0]];
    assign hdr = {DX, DY, SX, SY, 8'(cur_beats), ETH_RX_FRAME, 16'(cur_size), {(DW-64){1'b0}}};
    assign pop = eth_rx_out_noc_val && noc_eth_rx_out_rdy;
    assign room_used = occ - 2'(pop) + 2'(rv);

    // Read FSM: header plus first body read together, then one body read per free output slot
    always_comb begin
        rd_state_n = rd_state;
        rd_iss_n = rd_iss;
        rd_left_n = rd_left;
        desc_fp_n = desc_fp;
        issue = 1'b0;
        issue_last = 1'b0;
        hdr_push = 1'b0;
        if (rd_state == RD_IDLE) begin
            rd_state_n = desc_avail ? RD_HDR : RD_IDLE;
        end else if (rd_state == RD_HDR && room_used == 2'd0) begin
            hdr_push = 1'b1;
            issue = 1'b1;
            issue_last = cur_beats == BW'(1);
            rd_iss_n = rd_iss + PW'(1);
            rd_left_n = cur_beats - BW'(1);
            desc_fp_n = desc_fp + DPW'(1);
            rd_state_n = cur_beats == BW'(1) ? RD_IDLE : RD_BODY;
        end else if (rd_state == RD_BODY && room_used <= 2'd1) begin
            issue = 1'b1;
            issue_last = rd_left == BW'(1);
            rd_iss_n = rd_iss + PW'(1);
            rd_left_n = rd_left - BW'(1);
            rd_state_n = rd_left == BW'(1) ? RD_IDLE : RD_BODY;
        end
    end

    // Read-side state and issue pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= RD_IDLE;
            rd_iss <= '0;
            rd_left <= '0;
            desc_fp <= '0;
        end else begin
            rd_state <= rd_state_n;
            rd_iss <= rd_iss_n;
            rd_left <= rd_left_n;
            desc_fp <= desc_fp_n;
        end
    end

    // One-cycle buffer read with its valid/last tags
    always_ff @(posedge clk) begin
        if (issue) rdata <= buf_mem[rd_iss[AW-1:0]];
        if (rst) begin
            rv <= 1'b0;
            rv_last <= 1'b0;
        end else begin
            rv <= issue;
            rv_last <= issue_last;
        end
    end

    assign push = rv || hdr_push;
    assign push_ent = rv ? {1'b1, rv_last, rdata} : {2'b00, hdr};

    // Two-entry output queue: q0 drives the port, q1 is the skid slot; q0 only moves on a handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
            q0 <= '0;
            q1 <= '0;
        end else begin
            occ <= occ - 2'(pop) + 2'(push);
            if (pop) q0 <= q1;
            if (push && (occ - 2'(pop)) == 2'd0) q0 <= push_ent;
            if (push && (occ - 2'(pop)) == 2'd1) q1 <= push_ent;
        end
    end

    assign eth_rx_out_noc_val = occ != 2'd0;
    assign eth_rx_out_noc_data = q0[DW-1:0];

    // Buffer space and descriptors are released only as body flits are accepted downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            desc_rp <= '0;
        end else if (pop && q0[DW+1]) begin
            rd_ptr <= rd_ptr + PW'(1);
            desc_rp <= q0[DW] ? desc_rp + DPW'(1) : desc_rp;
        end
    end

`ifdef ETH_MAC_RX_DROP_CNT_EN
    // Saturating dropped-frame counter
    always_ff @(posedge clk) begin
        if (rst) drop_cnt <= '0;
        else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 32'd1;
    end
`else
    assign drop_cnt = {31'b0, drop & 1'b0};
`endif
endmodule

// File: tb/tb_eth_mac_rx_noc_out.sv
// tb_eth_mac_rx_noc_out: directed and random frames against a frame-level reference model
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 512
`endif
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 6
`endif
`ifndef MTU_SIZE_W
`define MTU_SIZE_W 16
`endif

module tb_eth_mac_rx_noc_out;
    localparam int DW = `NOC_DATA_WIDTH;
    localparam int B = `MAC_INTERFACE_W / 8;
    localparam int MAXF = 150;
    localparam int BUFN = 512;
    localparam int DESCN = 8;

    typedef struct {
        logic [DW-1:0] d;
        bit body;
        bit last;
    } flit_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mac_eth_rx_val = 1'b0;
    logic [`MAC_INTERFACE_W-1:0] mac_eth_rx_data = '0;
    logic mac_eth_rx_last = 1'b0;
    logic [`MAC_PADBYTES_W-1:0] mac_eth_rx_padbytes = '0;
    logic mac_eth_rx_err = 1'b0;
    logic eth_rx_out_noc_val;
    logic [DW-1:0] eth_rx_out_noc_data;
    logic noc_eth_rx_out_rdy = 1'b0;
    logic [31:0] drop_cnt;

    flit_t exp_q[$];
    int total = 0;
    int bad = 0;
    int occ_beats = 0;
    int desc_cnt = 0;
    int exp_drop = 0;
    int rdy_mode = 1;
    bit prev_stall = 0;
    bit prev_mid = 0;
    logic [DW-1:0] prev_data = '0;

    always #5 clk = ~clk;

    eth_mac_rx_noc_out #(.SRC_X(1), .SRC_Y(2), .DST_X(3), .DST_Y(4)) dut (
        .clk(clk),
        .rst(rst),
        .mac_eth_rx_val(mac_eth_rx_val),
        .mac_eth_rx_data(mac_eth_rx_data),
        .mac_eth_rx_last(mac_eth_rx_last),
        .mac_eth_rx_padbytes(mac_eth_rx_padbytes),
        .mac_eth_rx_err(mac_eth_rx_err),
        .eth_rx_out_noc_val(eth_rx_out_noc_val),
        .eth_rx_out_noc_data(eth_rx_out_noc_data),
        .noc_eth_rx_out_rdy(noc_eth_rx_out_rdy),
        .drop_cnt(drop_cnt)
    );

    function automatic int exp_cnt();
`ifdef ETH_MAC_RX_DROP_CNT_EN
        return exp_drop;
`else
        return 0;
`endif
    endfunction

    function automatic logic [DW-1:0] rnd_flit();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
        return d;
    endfunction

    function automatic logic [DW-1:0] hdr_flit(input int nb, input int size);
        return {8'd3, 8'd4, 8'd1, 8'd2, 8'(nb), 8'd18, 16'(size), {(DW-64){1'b0}}};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive MAC beat and rdy, check outputs against the scoreboard, advance past the edge
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit l, input int pad, input bit e);
        flit_t f;
        mac_eth_rx_val = v;
        mac_eth_rx_data = d;
        mac_eth_rx_last = l;
        mac_eth_rx_padbytes = `MAC_PADBYTES_W'(pad);
        mac_eth_rx_err = e;
        noc_eth_rx_out_rdy = rdy_mode == 2 ? ($urandom_range(0, 1) == 1) : (rdy_mode == 1);
        chk("drop_cnt", DW'(drop_cnt), DW'(exp_cnt()));
        if (prev_stall) begin
            chk("stall_val", DW'(eth_rx_out_noc_val), DW'(1));
            chk("stall_data", eth_rx_out_noc_data, prev_data);
        end
        if (prev_mid) chk("no_bubble", DW'(eth_rx_out_noc_val), DW'(1));
        prev_stall = eth_rx_out_noc_val && !noc_eth_rx_out_rdy;
        prev_data = eth_rx_out_noc_data;
        prev_mid = 0;
        if (eth_rx_out_noc_val && noc_eth_rx_out_rdy) begin
            if (exp_q.size() == 0) begin
                chk("extra_flit", DW'(eth_rx_out_noc_val), DW'(0));
            end else begin
                f = exp_q.pop_front();
                chk(f.body ? "body" : "header", eth_rx_out_noc_data, f.d);
                if (f.body) begin
                    occ_beats--;
                    if (f.last) desc_cnt--;
                end
                prev_mid = !f.last;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Send one frame; the model decides admission from its own occupancy and descriptor counts
    task automatic send_frame(input int nb, input int pad, input bit err, input int gap);
        bit ok;
        bit commit;
        int size;
        logic [DW-1:0] d;
        flit_t bodies[$];
        flit_t f;
        ok = (BUFN - occ_beats) >= MAXF && desc_cnt < DESCN;
        commit = ok && nb <= MAXF && !err;
        size = (nb - 1) * B + (B - pad);
        for (int i = 0; i < nb; i++) begin
            d = rnd_flit();
            f.d = d;
            f.body = 1;
            f.last = i == nb - 1;
            bodies.push_back(f);
            if (i == nb - 1) cycle(1, d, 1, pad, err);
            else cycle(1, d, 0, int'($urandom_range(0, B - 1)), $urandom_range(0, 1) == 1);
            if (!ok && i == 0) exp_drop++;
            else if (ok && nb > MAXF && i == MAXF) exp_drop++;
            else if (ok && nb <= MAXF && err && i == nb - 1) exp_drop++;
        end
        if (commit) begin
            f.d = hdr_flit(nb, size);
            f.body = 0;
            f.last = 0;
            exp_q.push_back(f);
            foreach (bodies[k]) exp_q.push_back(bodies[k]);
            occ_beats += nb;
            desc_cnt++;
        end
        repeat (gap) cycle(0, '0, 0, 0, 0);
    endtask

    task automatic drain(input int mode);
        int n = 0;
        rdy_mode = mode;
        while (exp_q.size() != 0 && n < 3000) begin
            cycle(0, '0, 0, 0, 0);
            n++;
        end
        chk("drain_left", DW'(exp_q.size()), DW'(0));
        rdy_mode = 1;
        repeat (3) cycle(0, '0, 0, 0, 0);
        chk("idle_val", DW'(eth_rx_out_noc_val), DW'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mac_eth_rx_val = 1'b0;
        mac_eth_rx_last = 1'b0;
        noc_eth_rx_out_rdy = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_val", DW'(eth_rx_out_noc_val), DW'(0));
        chk("rst_data", eth_rx_out_noc_data, DW'(0));
        chk("rst_drop", DW'(drop_cnt), DW'(0));
        rst = 1'b0;
        exp_q.delete();
        occ_beats = 0;
        desc_cnt = 0;
        exp_drop = 0;
        prev_stall = 0;
        prev_mid = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        rdy_mode = 1;
        send_frame(1, 0, 0, 0);
        drain(1);
        rdy_mode = 2;
        send_frame(24, 22, 0, 0);
        drain(2);
        rdy_mode = 1;
        send_frame(5, 0, 1, 0);
        send_frame(2, 0, 0, 0);
        drain(1);
        send_frame(151, 0, 0, 0);
        send_frame(2, 10, 0, 0);
        drain(1);
        rdy_mode = 0;
        repeat (5) send_frame(150, 7, 0, 0);
        drain(1);
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            send_frame($urandom_range(0, 9) == 0 ? int'($urandom_range(151, 154)) : int'($urandom_range(1, 12)),
                       int'($urandom_range(0, B - 1)), $urandom_range(0, 7) == 0, int'($urandom_range(0, 2)));
        end
        drain(2);
        rdy_mode = 0;
        send_frame(3, 0, 0, 2);
        for (int i = 0; i < 4; i++) cycle(1, rnd_flit(), 0, 0, 0);
        do_reset();
        rdy_mode = 1;
        send_frame(4, 5, 0, 1);
        drain(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/eth_mac_rx_noc_out.md
# eth_mac_rx_noc_out

MAC-facing ingress stage feeding the Ethernet RX tile. Takes the non-stallable MAC receive stream (data/last/padbytes/error), stores each frame whole in an on-chip buffer, and emits it as one NoC message: a header flit carrying the frame size, then one body flit per MAC beat. Output is val/rdy and goes into the tile's valrdy-to-credit converter toward the RX tile's router. Frames arriving without room, errored, or oversize are dropped whole.

## Interface

Parameters:
- SRC_X, -1, this tile's X coordinate (header src_x)
- SRC_Y, -1, this tile's Y coordinate (header src_y)
- DST_X, -1, Ethernet RX tile X (header dst_x)
- DST_Y, -1, Ethernet RX tile Y (header dst_y)
- BUF_FLITS, 512, frame buffer depth in beats; power of two
- MAX_FRAME_FLITS, 150, largest accepted frame in beats
- SIZE_FIFO_DEPTH, 8, committed-frame descriptor FIFO depth; power of two

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mac_eth_rx_val  in  1  beat valid; no ready, MAC never stalls
- mac_eth_rx_data  in  `MAC_INTERFACE_W  beat data (width equals `NOC_DATA_WIDTH)
- mac_eth_rx_last  in  1  final beat of frame
- mac_eth_rx_padbytes  in  `MAC_PADBYTES_W  invalid trailing bytes in last beat
- mac_eth_rx_err  in  1  frame bad (FCS/PHY); sampled only with last
- eth_rx_out_noc_val  out  1  flit valid
- eth_rx_out_noc_data  out  `NOC_DATA_WIDTH  flit
- noc_eth_rx_out_rdy  in  1  downstream ready
- drop_cnt  out  32  frames dropped

## Operation

- Beat B = `MAC_INTERFACE_W/8 bytes.
- Write FSM: WR_IDLE, WR_ACCEPT, WR_DROP. First valid beat in WR_IDLE is frame start.
- Start accepted iff free beats ≥ MAX_FRAME_FLITS and descriptor FIFO not full; else WR_DROP (drop_cnt += 1 at start).
- WR_ACCEPT: each beat written at speculative pointer wr_spec; byte count += B (non-last) or B − padbytes (last), width `MTU_SIZE_W.
- Last beat, no err, beats ≤ MAX_FRAME_FLITS: wr_commit ← wr_spec+1, push {size, beats} to descriptor FIFO, → WR_IDLE.
- Last with err: wr_spec ← wr_commit, drop_cnt += 1, → WR_IDLE.
- Beat count exceeds MAX_FRAME_FLITS: wr_spec ← wr_commit, drop_cnt += 1, → WR_DROP.
- WR_DROP: discard beats until last, → WR_IDLE.
- Single-beat frame legal: size = B − padbytes.
- Free beats = BUF_FLITS − (wr_spec − rd_ptr); pointers one bit wider than index, wrap modulo 2·BUF_FLITS.
- Read FSM: RD_IDLE, RD_HDR, RD_BODY. Reads only below wr_commit; never sees uncommitted data.
- Descriptor non-empty → RD_HDR: header flit (beehive NoC header) with dst_x/y=DST_X/Y, src_x/y=SRC_X/Y, msg_len=beats, msg_type=ETH_RX_FRAME, frame size in metadata field; other bits zero.
- RD_BODY: buffer beats in order, unmodified (pad bytes as received); rd_ptr advances per accepted flit; last accepted body flit pops descriptor, → RD_IDLE.
- Simultaneous write-start check and read pop: check uses rd_ptr pre-pop (conservative).

## Timing

- Reset: eth_rx_out_noc_val=0, eth_rx_out_noc_data=0, drop_cnt=0, all pointers 0, both FSMs idle, descriptor FIFO empty. rst also resets the MAC, so the stream restarts at a frame boundary; a partial frame in progress is lost and not counted.
- Buffer is 1-cycle-read RAM; output register plus prefetch (skid) keeps val stable until rdy.
- Header val no earlier than 2 cycles after committing last beat.
- rdy held high: header then body flits back-to-back, zero bubbles; back-to-back frames one idle cycle max between last body and next header.
- val/data must not change while val=1 and rdy=0.
- drop_cnt updates cycle after the dropping event; saturates at 2^32−1.

## Configuration

- ETH_MAC_RX_DROP_CNT_EN: defined → drop_cnt counter implemented as above. Undefined → counter logic removed, drop_cnt tied 0; dropping behaviour unchanged.

## Test plan

- 64-byte frame (B=64, 1 beat, padbytes 0), rdy=1 → header (msg_len 1, size 64) then 1 body flit equal to input; drop_cnt 0.
- 1514-byte frame (24 beats, last padbytes 22), random rdy → header size 1514, msg_len 24, 24 body flits in order, val stable under stall.
- Frame with err on last, then good 128-byte frame → only second frame emitted, drop_cnt 1, wr_spec rewound (buffer full capacity restored).
- 151-beat frame → nothing emitted, drop_cnt 1; following 2-beat frame emitted normally.
- rdy=0 permanently, BUF_FLITS=512, 150-beat frames back-to-back → frames 1–3 committed, frame 4 dropped (free 62 < 150), drop_cnt increments per frame; releasing rdy outputs exactly frames 1–3.
- rst asserted mid-frame → outputs 0 next cycle, drop_cnt 0, next frame emitted correctly.
